// File: rtl/display_value_formatter.sv
// Formats a 16-bit value for the four-digit seven-segment scanner: raw hex
// pass-through or BCD via an iterative double-dabble datapath. The result is
// held stable between updates so the scanner never sees a partial conversion.
module display_value_formatter #(
    parameter logic [15:0] OVF_PATTERN        = 16'hEEEE,
    parameter bit          ENABLE_AFTER_RESET = 1'b0
) (
    input  logic        clk_1K,
    input  logic        reset,
    input  logic [15:0] in_value,
    input  logic        in_decimal,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [15:0] Number,
    output logic        DisplayEnable,
    output logic        conv_done,
    output logic        overflow
);

    localparam int unsigned VAL_W   = 16;
    localparam int unsigned BCD_W   = 20;
    localparam int unsigned DIGITS  = 5;
    localparam int unsigned CNT_W   = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HEX  = 2'd1,
        CONV = 2'd2
    } state_t;

    state_t             state;
    logic [VAL_W-1:0]   shreg;
    logic [BCD_W-1:0]   bcd;
    logic [CNT_W-1:0]   cnt;
    logic [BCD_W-1:0]   bcd_adj;
    logic [BCD_W-1:0]   bcd_next;

    // Add-3 correction on every BCD nibble >= 5, then shift in the next input bit.
    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd[i*4 +: 4] >= 4'd5) begin
                bcd_adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
            end
        end
        bcd_next = {bcd_adj[BCD_W-2:0], shreg[VAL_W-1]};
    end

    // Control FSM, conversion datapath and registered display outputs.
    always_ff @(posedge clk_1K or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            in_ready      <= 1'b1;
            Number        <= 16'h0000;
            DisplayEnable <= ENABLE_AFTER_RESET;
            conv_done     <= 1'b0;
            overflow      <= 1'b0;
            cnt           <= '0;
            shreg         <= '0;
            bcd           <= '0;
        end else begin
            conv_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        shreg    <= in_value;
                        bcd      <= '0;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        state    <= in_decimal ? CONV : HEX;
                    end
                end
                HEX: begin
                    Number        <= shreg;
                    overflow      <= 1'b0;
                    DisplayEnable <= 1'b1;
                    conv_done     <= 1'b1;
                    in_ready      <= 1'b1;
                    state         <= IDLE;
                end
                CONV: begin
                    bcd   <= bcd_next;
                    shreg <= {shreg[VAL_W-2:0], 1'b0};
                    cnt   <= cnt + 4'd1;
                    if (cnt == 4'd15) begin
                        // Fifth digit non-zero means the value exceeded 9999.
                        if (bcd_next[19:16] == 4'd0) begin
                            Number   <= bcd_next[15:0];
                            overflow <= 1'b0;
                        end else begin
                            Number   <= OVF_PATTERN;
                            overflow <= 1'b1;
                        end
                        DisplayEnable <= 1'b1;
                        conv_done     <= 1'b1;
                        in_ready      <= 1'b1;
                        state         <= IDLE;
                    end
                end
                default: begin
                    in_ready <= 1'b1;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_display_value_formatter.sv
// Self-checking bench for display_value_formatter: directed table, random
// values against an arithmetic reference, back-to-back and mid-conversion reset.
module tb_display_value_formatter;

    logic        clk_1K = 1'b0;
    logic        reset;
    logic [15:0] in_value;
    logic        in_decimal;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] Number;
    logic        DisplayEnable;
    logic        conv_done;
    logic        overflow;

    int n_checks = 0;
    int n_fail   = 0;

    display_value_formatter dut (
        .clk_1K        (clk_1K),
        .reset         (reset),
        .in_value      (in_value),
        .in_decimal    (in_decimal),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .Number        (Number),
        .DisplayEnable (DisplayEnable),
        .conv_done     (conv_done),
        .overflow      (overflow)
    );

    always #5 clk_1K = ~clk_1K;

    typedef struct {
        string       name;
        logic [15:0] value;
        logic        dec;
        logic [15:0] exp_num;
        logic        exp_ovf;
        int          exp_lat;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: decimal digits by division, overflow above 9999, hex untouched.
    function automatic logic [15:0] model_num(input int v, input bit dec);
        if (!dec) return 16'(v);
        if (v > 9999) return 16'hEEEE;
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic run_one(input string name, input logic [15:0] v, input logic dec,
                           input logic [15:0] en, input logic eo, input int el);
        logic [15:0] prev;
        int          lat;
        bit          stable;
        @(negedge clk_1K);
        check({name, " ready_idle"}, 32'(in_ready), 32'd1);
        prev       = Number;
        in_value   = v;
        in_decimal = dec;
        in_valid   = 1'b1;
        @(negedge clk_1K);
        in_valid = 1'b0;
        check({name, " busy"}, 32'(in_ready), 32'd0);
        lat    = 0;
        stable = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk_1K);
            if (conv_done) begin
                lat = k;
                break;
            end
            if (Number !== prev) stable = 1'b0;
        end
        check({name, " latency"}, 32'(lat), 32'(el));
        check({name, " stable"}, 32'(stable), 32'd1);
        check({name, " number"}, 32'(Number), 32'(en));
        check({name, " overflow"}, 32'(overflow), 32'(eo));
        check({name, " enable"}, 32'(DisplayEnable), 32'd1);
        check({name, " ready_after"}, 32'(in_ready), 32'd1);
        @(negedge clk_1K);
        check({name, " done_pulse"}, 32'(conv_done), 32'd0);
    endtask

    initial begin
        logic [15:0] prev;
        logic [15:0] expn;
        bit          ok_num;
        bit          ok_done;
        bit          ok_rst;

        reset      = 1'b1;
        in_value   = '0;
        in_decimal = 1'b0;
        in_valid   = 1'b0;
        #1;
        check("rst_num", 32'(Number), 32'h0);
        check("rst_en", 32'(DisplayEnable), 32'd0);
        check("rst_ready", 32'(in_ready), 32'd1);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_done", 32'(conv_done), 32'd0);
        repeat (3) @(negedge clk_1K);
        check("rst_hold_done", 32'(conv_done), 32'd0);
        reset = 1'b0;
        @(negedge clk_1K);
        check("post_rst_num", 32'(Number), 32'h0);
        check("post_rst_en", 32'(DisplayEnable), 32'd0);

        vecs.push_back('{"dec1234",  16'd1234,  1'b1, 16'h1234, 1'b0, 16});
        vecs.push_back('{"dec9999",  16'd9999,  1'b1, 16'h9999, 1'b0, 16});
        vecs.push_back('{"dec0",     16'd0,     1'b1, 16'h0000, 1'b0, 16});
        vecs.push_back('{"dec10000", 16'd10000, 1'b1, 16'hEEEE, 1'b1, 16});
        vecs.push_back('{"dec65535", 16'd65535, 1'b1, 16'hEEEE, 1'b1, 16});
        vecs.push_back('{"dec42",    16'd42,    1'b1, 16'h0042, 1'b0, 16});
        vecs.push_back('{"hexBEEF",  16'hBEEF,  1'b0, 16'hBEEF, 1'b0, 1});
        vecs.push_back('{"dec10000b",16'd10000, 1'b1, 16'hEEEE, 1'b1, 16});
        vecs.push_back('{"hexFFFF",  16'hFFFF,  1'b0, 16'hFFFF, 1'b0, 1});
        foreach (vecs[i])
            run_one(vecs[i].name, vecs[i].value, vecs[i].dec,
                    vecs[i].exp_num, vecs[i].exp_ovf, vecs[i].exp_lat);

        for (int i = 0; i < 20; i++) begin
            int v;
            bit d;
            v = int'($urandom_range(0, 65535));
            if ($urandom_range(0, 1) == 1) v = int'($urandom_range(0, 9999));
            d = 1'($urandom_range(0, 1));
            run_one($sformatf("rand%0d", i), 16'(v), d, model_num(v, d),
                    (d && v > 9999), d ? 16 : 1);
        end

        // Back-to-back: 7 held valid while 500 converts.
        @(negedge clk_1K);
        prev       = Number;
        in_value   = 16'd500;
        in_decimal = 1'b1;
        in_valid   = 1'b1;
        @(negedge clk_1K);
        in_value = 16'd7;
        expn     = prev;
        ok_num   = 1'b1;
        ok_done  = 1'b1;
        for (int k = 1; k <= 33; k++) begin
            @(negedge clk_1K);
            if (k == 16) expn = 16'h0500;
            if (k == 33) expn = 16'h0007;
            if (Number !== expn) ok_num = 1'b0;
            if (conv_done !== ((k == 16) || (k == 33))) ok_done = 1'b0;
            if (k == 16) check("b2b first", 32'(Number), 32'h0500);
        end
        in_valid = 1'b0;
        check("b2b number_seq", 32'(ok_num), 32'd1);
        check("b2b done_seq", 32'(ok_done), 32'd1);
        check("b2b final", 32'(Number), 32'h0007);

        // Reset in the middle of converting 8888.
        @(negedge clk_1K);
        in_value   = 16'd8888;
        in_decimal = 1'b1;
        in_valid   = 1'b1;
        @(negedge clk_1K);
        in_valid = 1'b0;
        repeat (7) @(negedge clk_1K);
        @(posedge clk_1K);
        #1 reset = 1'b1;
        #1;
        check("midrst_num", 32'(Number), 32'h0);
        check("midrst_en", 32'(DisplayEnable), 32'd0);
        check("midrst_ready", 32'(in_ready), 32'd1);
        check("midrst_ovf", 32'(overflow), 32'd0);
        ok_rst = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk_1K);
            if (conv_done !== 1'b0) ok_rst = 1'b0;
            if (k == 2) reset = 1'b0;
        end
        check("midrst_no_done", 32'(ok_rst), 32'd1);
        check("midrst_num_idle", 32'(Number), 32'h0);
        run_one("dec8888", 16'd8888, 1'b1, 16'h8888, 1'b0, 16);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/display_value_formatter.md
Name: display_value_formatter

Overview:
- Sits directly upstream of the four-digit seven-segment scanner. Produces the scanner's 16-bit packed nibble word (Number) and its DisplayEnable.
- Accepts a 16-bit value from the CPU-side display register through a valid/ready handshake, with the value already synchronised to clk_1K.
- Presents the value either as raw hex or as a four-digit decimal (BCD). Decimal conversion uses an iterative shift-add-3 (double-dabble) datapath clocked by clk_1K.
- Holds the last result stable so the scanner never sees a partial conversion.

Parameters:
- OVF_PATTERN, 16'hEEEE, Number value shown when a decimal conversion exceeds 9999.
- ENABLE_AFTER_RESET, 0, reset value of DisplayEnable. 1 means the display is on from reset and shows 0000.

Ports:
- clk_1K  input  1  1 kHz system display clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high.
- in_value  input  16  unsigned value to display.
- in_decimal  input  1  1 = convert to BCD, 0 = pass through as hex; sampled with in_value.
- in_valid  input  1  in_value/in_decimal are valid this cycle.
- in_ready  output  1  block can accept a value (high only in IDLE).
- Number  output  16  packed digits to the scanner; [15:12] is the most significant digit.
- DisplayEnable  output  1  scanner enable.
- conv_done  output  1  one-cycle pulse when Number has just been updated.
- overflow  output  1  sticky per result: 1 if the current Number is OVF_PATTERN due to a value >9999.

Behaviour:
- Interface: reset is asynchronous, active-high; clock is clk_1K. Reset applies immediately, independent of the clock.
- Reset values: state=IDLE, in_ready=1, Number=16'h0000, DisplayEnable=ENABLE_AFTER_RESET, conv_done=0, overflow=0, iteration counter=0, shift/BCD registers=0.
- FSM states: IDLE, HEX, CONV.
- IDLE:
  - Acceptance occurs at a rising edge with in_valid=1 and in_ready=1; call this edge E0.
  - At E0 the block captures in_value into a 16-bit shift register and clears the 20-bit BCD accumulator and counter.
  - Next state is CONV if in_decimal=1, otherwise HEX.
  - in_ready falls after E0.
- HEX: at edge E1, Number<=captured value, overflow<=0, DisplayEnable<=1, conv_done=1 for that cycle, state<=IDLE. Accept-to-update latency is 1 cycle.
- CONV: one iteration per edge E1..E16. Each iteration:
  - adds 3 to every BCD nibble >=5 (all five nibbles evaluated in parallel, combinationally);
  - then shifts {bcd[18:0], shreg[15]} into bcd and shifts shreg left by 1;
  - increments the counter.
- At E16 (counter reaches 15 before the edge), with R the final 20-bit BCD:
  - if R[19:16]==0, Number<=R[15:0] and overflow<=0;
  - else Number<=OVF_PATTERN and overflow<=1;
  - in both cases DisplayEnable<=1, conv_done pulses high for one cycle, and state<=IDLE.
  - Accept-to-update latency is 16 cycles.
- Number, overflow and DisplayEnable change only at the final edge of HEX/CONV or on reset. They are stable at all other times.
- in_valid while busy (in_ready=0) is ignored; the upstream side must hold or retry. Nothing is queued.
- Back-to-back: in_ready is 1 in the cycle after the update edge. A new value held valid is accepted at the next edge, so the minimum spacing between decimal results is 17 cycles.
- Width rules: all 16-bit inputs are unsigned. 0..9999 display exactly. 10000..65535 produce overflow. Hex mode never overflows.
- Reset mid-conversion aborts immediately. All outputs return to their reset values, with no conv_done pulse.
- DisplayEnable, once 1, stays 1 until reset.

Test Plan:
- Reset with ENABLE_AFTER_RESET=0 -> Number=0000, DisplayEnable=0, in_ready=1, overflow=0, conv_done=0 during and after reset.
- Decimal 1234 (16'h04D2) accepted at E0 -> Number=16'h1234 at E16, conv_done high exactly one cycle, DisplayEnable=1, in_ready high from E16. Repeat with 9999 -> 16'h9999, and 0 -> 16'h0000.
- Decimal 10000 and 65535 -> Number=16'hEEEE, overflow=1 at E16. Then decimal 42 -> Number=16'h0042, overflow=0.
- Hex 16'hBEEF with in_decimal=0 -> Number=16'hBEEF at E1, overflow=0, conv_done at E1.
- Decimal 500 accepted, then in_valid held high with 16'h0007 during cycles E1..E16 -> Number becomes 16'h0500 at E16. 7 is accepted at E16+1 and Number=16'h0007 at E16+17. No other value ever appears on Number.
- Reset asserted at E8 of a decimal 8888 conversion -> Number=0000, state IDLE, no conv_done. After release, decimal 8888 converts cleanly to 16'h8888.
